mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//   Shares one signed 32x32 sequential multiplier (start-pulse / finish-level
//   interface, 64-bit product) between NUM_REQ requesters.
//   Round-robin arbitration; operands latched at grant; per-op watchdog.
//   Sits between client blocks (e.g. ALU / MAC sequencers) and the multiplier.
// PARAMETERS
//   NUM_REQ      2    number of requesters (2..8)
//   TIMEOUT      255  max cycles in BUSY before abort (8-bit counter, >=140)
// PORTS
//   clk          in   1            system clock, all state on posedge
//   rst          in   1            asynchronous, active-high reset
//   req_valid    in   NUM_REQ      requester i wants a multiply
//   req_a        in   NUM_REQ*32   operand A of requester i, bits [32i+31:32i]
//   req_b        in   NUM_REQ*32   operand B of requester i, same packing
//   req_grant    out  NUM_REQ      one-hot 1-cycle pulse: operands of i latched
//   req_done     out  NUM_REQ      one-hot 1-cycle pulse: res_p valid for i
//   res_p        out  64           signed product; held until next done
//   res_err      out  1            valid with req_done: 1 = watchdog abort
//   busy         out  1            1 from grant until the cycle after done
//   mul_start    out  1            to multiplier start/rst input
//   mul_a        out  32           latched operand A to multiplier
//   mul_b        out  32           latched operand B to multiplier
//   mul_finish   in   1            multiplier finish level
//   mul_p        in   64           multiplier product
// BEHAVIOUR
//   Reset: state IDLE; req_grant=0, req_done=0, res_p=0, res_err=0, busy=0,
//     mul_start=0, mul_a=0, mul_b=0, rr pointer=NUM_REQ-1, counter=0.
//   Reset mid-operation aborts silently: no done pulse, multiplier abandoned.
//   FSM: IDLE -> START -> ARM -> BUSY -> DONE -> IDLE.
//   IDLE: if any req_valid, pick first set index cyclically after rr pointer;
//     same edge: latch req_a/req_b into mul_a/mul_b, pulse req_grant[i],
//     rr pointer<=i, busy<=1, -> START. No request: stay.
//   START: mul_start=1 for exactly one full cycle (spans a negedge so the
//     multiplier samples it); -> ARM.
//   ARM: mul_start=0; mul_finish ignored (may be stale high from the
//     previous op); -> BUSY.
//   BUSY: counter increments each cycle; mul_finish==1 -> res_p<=mul_p,
//     res_err<=0, -> DONE. Counter reaches TIMEOUT first -> res_p<=0,
//     res_err<=1, -> DONE. Finish and timeout on same cycle: finish wins.
//   DONE: req_done[i]=1 for one cycle, busy=0 on exit, counter<=0, -> IDLE.
//     Next grant earliest the cycle after DONE.
//   Requester contract: hold req_valid until grant. req_valid still high
//     in the IDLE cycle after done is a new request. Operands may change
//     after grant.
//   req_valid dropped after grant is ignored; the op completes and done fires.
//   mul_a/mul_b stable from START until the next grant.
//   Fairness: with all requesters continuously valid, grants rotate
//     0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 ops.
//   Latency: grant -> done = 3 + multiplier cycles (about 130-135 for 32 bits).
// TESTING
//   1 single: req_valid=01, a0=3, b0=-5 -> grant=01, done=01,
//     res_p=64'hFFFF_FFFF_FFFF_FFF1, err=0.
//   2 contention: req_valid=11 from reset, a0=7,b0=6, a1=-2,b1=-9 ->
//     req 0 granted first, res_p=42; then req 1, res_p=18; held high ->
//     grant order 0,1,0,1.
//   3 stale finish: after test 1, leave mul_finish high, issue a1=2, b1=2 ->
//     no done before mul_finish drops and rises; res_p=4.
//   4 watchdog: stub multiplier, finish tied 0 -> done after TIMEOUT busy
//     cycles, res_err=1, res_p=0; next request serviced normally.
//   5 reset mid-BUSY: assert rst 50 cycles after grant -> all outputs to
//     reset values asynchronously, no done; new request after release
//     completes correctly.
//   6 extremes: a=32'h8000_0000, b=32'h8000_0000 -> res_p=64'h4000_0000_0000_0000.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one sequential signed
// 32x32 multiplier among NUM_REQ requesters, with a per-op watchdog.
// Ports:
//   clk, rst            clock, async active-high reset
//   req_valid/a/b       per-requester request and packed operands
//   req_grant/done      one-hot pulses: operands latched / result valid
//   res_p, res_err      product (held) and watchdog-abort flag
//   busy                high from grant until the cycle after done
//   mul_start/a/b       start pulse and latched operands to multiplier
//   mul_finish, mul_p   multiplier finish level and product
module mul_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [63:0]             res_p,
  output logic                    res_err,
  output logic                    busy,
  output logic                    mul_start,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic                    mul_finish,
  input  logic [63:0]             mul_p
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [7:0]    cnt;
  logic [7:0]    cnt_nx;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;

  assign cnt_nx = cnt + 8'd1;

  // Walk the requesters starting just after the last owner; the first
  // valid one found wins, which gives the round-robin rotation.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    cand  = rr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == IW'(NUM_REQ - 1)) cand = '0;
      else                          cand = cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= IW'(NUM_REQ - 1);
      cnt       <= '0;
      req_grant <= '0;
      req_done  <= '0;
      res_p     <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      req_grant <= '0;
      req_done  <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            req_grant <= NUM_REQ'(1) << pick;
            rr        <= pick;
            mul_a     <= req_a[{pick, 5'd0} +: 32];
            mul_b     <= req_b[{pick, 5'd0} +: 32];
            busy      <= 1'b1;
            mul_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          mul_start <= 1'b0;
          state     <= ARM;
        end
        // finish may still be high from the previous op here
        ARM: state <= BUSY;
        BUSY: begin
          if (mul_finish) begin
            res_p    <= mul_p;
            res_err  <= 1'b0;
            req_done <= NUM_REQ'(1) << rr;
            state    <= DONE;
          end else if (cnt_nx == 8'(TIMEOUT)) begin
            res_p    <= '0;
            res_err  <= 1'b1;
            req_done <= NUM_REQ'(1) << rr;
            state    <= DONE;
          end else begin
            cnt <= cnt_nx;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed bench for mul_share_arbiter with a
// behavioural sequential multiplier whose finish level stays high.
module tb_mul_share_arbiter;

  localparam int L  = 10;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [1:0]  req_grant;
  logic [1:0]  req_done;
  logic [63:0] res_p;
  logic        res_err;
  logic        busy;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_finish;
  logic [63:0] mul_p;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  mul_share_arbiter #(.NUM_REQ(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_grant(req_grant), .req_done(req_done),
    .res_p(res_p), .res_err(res_err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_finish(mul_finish), .mul_p(mul_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier model: samples start on negedge, keeps the old finish
  // level for one more cycle, then counts L cycles and raises finish
  logic        stub = 1'b0;
  logic        st_s = 1'b0;
  logic        pend = 1'b0;
  logic        fin  = 1'b0;
  logic [7:0]  mcnt = '0;
  logic [63:0] prod = '0;
  logic [63:0] mp   = '0;

  assign mul_finish = stub ? 1'b0 : fin;
  assign mul_p      = mp;

  always @(negedge clk) st_s <= mul_start;

  always @(posedge clk) begin
    if (st_s) begin
      mcnt <= 8'(L);
      pend <= 1'b1;
      prod <= $signed({{32{mul_a[31]}}, mul_a}) *
              $signed({{32{mul_b[31]}}, mul_b});
    end else if (pend) begin
      if (mcnt == 8'd0) begin
        fin  <= 1'b1;
        mp   <= prod;
        pend <= 1'b0;
      end else begin
        fin  <= 1'b0;
        mcnt <= mcnt - 8'd1;
      end
    end
  end

  task automatic wait_grant(output logic [1:0] g, output int t);
    g = '0;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_grant != 2'b00) begin
        g = req_grant;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(input int lim, output logic [1:0] d,
                           output int t);
    d = '0;
    t = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (req_done != 2'b00) begin
        d = req_done;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if (req_grant !== 2'b00 || req_done !== 2'b00)
      $display("FAIL reset_pulses: grant=%b done=%b want 00/00",
               req_grant, req_done);
    else passed++;
    total++;
    if (res_p !== 64'd0 || res_err !== 1'b0)
      $display("FAIL reset_res: res_p=%h err=%b want 0/0", res_p, res_err);
    else passed++;
    total++;
    if (busy !== 1'b0 || mul_start !== 1'b0)
      $display("FAIL reset_ctl: busy=%b start=%b want 0/0", busy, mul_start);
    else passed++;
    total++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0)
      $display("FAIL reset_ops: a=%h b=%h want 0/0", mul_a, mul_b);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [1:0] g, d;
    int tg, td;
    req_a[31:0] = 32'd3;
    req_b[31:0] = 32'hFFFF_FFFB;
    req_valid   = 2'b01;
    wait_grant(g, tg);
    req_valid = 2'b00;
    total++;
    if (g !== 2'b01) $display("FAIL single_grant: got %b want 01", g);
    else passed++;
    total++;
    if (busy !== 1'b1 || mul_start !== 1'b1)
      $display("FAIL single_start: busy=%b start=%b want 1/1",
               busy, mul_start);
    else passed++;
    total++;
    if (mul_a !== 32'd3 || mul_b !== 32'hFFFF_FFFB)
      $display("FAIL single_ops: a=%h b=%h want 3/fffffffb", mul_a, mul_b);
    else passed++;
    @(negedge clk);
    total++;
    if (mul_start !== 1'b0)
      $display("FAIL single_start_len: start=%b want 0", mul_start);
    else passed++;
    wait_done(100, d, td);
    total++;
    if (d !== 2'b01) $display("FAIL single_done: got %b want 01", d);
    else passed++;
    total++;
    if (res_p !== 64'hFFFF_FFFF_FFFF_FFF1 || res_err !== 1'b0)
      $display("FAIL single_res: res_p=%h err=%b want fffffffffffffff1/0",
               res_p, res_err);
    else passed++;
    total++;
    if (td - tg !== L + 3)
      $display("FAIL single_latency: got %0d want %0d", td - tg, L + 3);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy_done: got %b want 1", busy);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_done !== 2'b00)
      $display("FAIL single_after: busy=%b done=%b want 0/00",
               busy, req_done);
    else passed++;
  endtask

  task automatic test_stale_finish;
    logic [1:0] g, d;
    int tg, td;
    req_a[63:32] = 32'd2;
    req_b[63:32] = 32'd2;
    req_valid    = 2'b10;
    wait_grant(g, tg);
    req_valid = 2'b00;
    total++;
    if (g !== 2'b10) $display("FAIL stale_grant: got %b want 10", g);
    else passed++;
    wait_done(100, d, td);
    total++;
    if (d !== 2'b10) $display("FAIL stale_done: got %b want 10", d);
    else passed++;
    total++;
    if (td - tg !== L + 3)
      $display("FAIL stale_latency: got %0d want %0d", td - tg, L + 3);
    else passed++;
    total++;
    if (res_p !== 64'd4 || res_err !== 1'b0)
      $display("FAIL stale_res: res_p=%h err=%b want 4/0", res_p, res_err);
    else passed++;
  endtask

  task automatic test_contention;
    logic [1:0] g, d, eg;
    logic [63:0] ep;
    int tg, td;
    rst = 1'b1;
    req_a = {32'hFFFF_FFFE, 32'd7};
    req_b = {32'hFFFF_FFF7, 32'd6};
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ep = (k % 2 == 0) ? 64'd42 : 64'd18;
      wait_grant(g, tg);
      total++;
      if (g !== eg) $display("FAIL rr_grant%0d: got %b want %b", k, g, eg);
      else passed++;
      wait_done(100, d, td);
      if (k == 3) req_valid = 2'b00;
      total++;
      if (d !== eg || res_p !== ep)
        $display("FAIL rr_done%0d: done=%b res_p=%h want %b/%h",
                 k, d, res_p, eg, ep);
      else passed++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL rr_idle: busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_watchdog;
    logic [1:0] g, d;
    int tg, td;
    stub = 1'b1;
    req_a[31:0] = 32'd5;
    req_b[31:0] = 32'd5;
    req_valid   = 2'b01;
    wait_grant(g, tg);
    req_valid = 2'b00;
    total++;
    if (g !== 2'b01) $display("FAIL wd_grant: got %b want 01", g);
    else passed++;
    wait_done(400, d, td);
    total++;
    if (d !== 2'b01) $display("FAIL wd_done: got %b want 01", d);
    else passed++;
    total++;
    if (res_err !== 1'b1 || res_p !== 64'd0)
      $display("FAIL wd_res: err=%b res_p=%h want 1/0", res_err, res_p);
    else passed++;
    total++;
    if (td - tg !== TO + 2)
      $display("FAIL wd_latency: got %0d want %0d", td - tg, TO + 2);
    else passed++;
    stub = 1'b0;
    req_a[63:32] = 32'hFFFF_FFFD;
    req_b[63:32] = 32'd4;
    req_valid    = 2'b10;
    wait_grant(g, tg);
    req_valid = 2'b00;
    wait_done(100, d, td);
    total++;
    if (d !== 2'b10 || res_err !== 1'b0 ||
        res_p !== 64'hFFFF_FFFF_FFFF_FFF4)
      $display("FAIL wd_next: done=%b err=%b res_p=%h want 10/0/fff..ff4",
               d, res_err, res_p);
    else passed++;
  endtask

  task automatic test_reset_mid_busy;
    logic [1:0] g, d;
    int tg, td, seen;
    req_a[31:0] = 32'd9;
    req_b[31:0] = 32'd9;
    req_valid   = 2'b01;
    wait_grant(g, tg);
    req_valid = 2'b00;
    stub = 1'b1;
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || req_grant !== 2'b00 || req_done !== 2'b00)
      $display("FAIL mid_rst_ctl: busy=%b grant=%b done=%b want 0",
               busy, req_grant, req_done);
    else passed++;
    total++;
    if (res_p !== 64'd0 || res_err !== 1'b0)
      $display("FAIL mid_rst_res: res_p=%h err=%b want 0/0", res_p, res_err);
    else passed++;
    total++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0 || mul_start !== 1'b0)
      $display("FAIL mid_rst_ops: a=%h b=%h start=%b want 0",
               mul_a, mul_b, mul_start);
    else passed++;
    stub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_done != 2'b00 || busy) seen++;
    end
    total++;
    if (seen !== 0)
      $display("FAIL mid_rst_silent: %0d active cycles want 0", seen);
    else passed++;
    req_a = {32'd1, 32'hFFFF_FFF9};
    req_b = {32'd1, 32'd3};
    req_valid = 2'b11;
    wait_grant(g, tg);
    req_valid = 2'b00;
    total++;
    if (g !== 2'b01) $display("FAIL mid_rst_grant: got %b want 01", g);
    else passed++;
    wait_done(100, d, td);
    total++;
    if (d !== 2'b01 || res_p !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL mid_rst_res2: done=%b res_p=%h want 01/fff..feb",
               d, res_p);
    else passed++;
  endtask

  task automatic test_extremes;
    logic [1:0] g, d;
    int tg, td;
    req_a[31:0] = 32'h8000_0000;
    req_b[31:0] = 32'h8000_0000;
    req_valid   = 2'b01;
    wait_grant(g, tg);
    req_valid = 2'b00;
    wait_done(100, d, td);
    total++;
    if (d !== 2'b01 || res_p !== 64'h4000_0000_0000_0000)
      $display("FAIL extremes: done=%b res_p=%h want 01/4000000000000000",
               d, res_p);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stale_finish();
    test_contention();
    test_watchdog();
    test_reset_mid_busy();
    test_extremes();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
